// File: rtl/gshare_btb_predictor.sv
// -----------------------------------------------------------------------------
// gshare_btb_predictor
//   IF-stage branch predictor: a direct-mapped tagged BTB paired with a gshare
//   pattern history table (saturating counters indexed by PC XOR the
//   speculative global history register). Lookup is purely combinational on
//   the fetch PC; training, history checkpointing and misprediction recovery
//   arrive from EX.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_rdy             global enable; 0 freezes all state
//   i_pc              fetch PC being predicted
//   i_fetch_adv       IF accepts i_pc this cycle (advances the GHR)
//   o_pre_jmp         predict taken
//   o_pre_target      predicted target (0 when not taken)
//   o_pre_hist        GHR used for this lookup, carried down the pipeline
//   i_ex_valid        EX reports a resolved control-transfer instruction
//   i_ex_pc           PC of the resolved instruction
//   i_ex_br           conditional branch
//   i_ex_uncond       JAL/JALR (always taken); wins if i_ex_br is also set
//   i_ex_taken        actual direction
//   i_ex_target       actual target
//   i_ex_hist         history that was returned with this instruction's lookup
//   i_ex_mispred      direction/target mispredicted; restores the GHR
//
// HIST_W must lie in 1..PHT_IDX_W and CTR_W must be at least 2.
// -----------------------------------------------------------------------------
module gshare_btb_predictor #(
  parameter int ADDR_W    = 32,
  parameter int BTB_IDX_W = 6,
  parameter int PHT_IDX_W = 8,
  parameter int HIST_W    = 8,
  parameter int CTR_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rdy,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_fetch_adv,
  output logic              o_pre_jmp,
  output logic [ADDR_W-1:0] o_pre_target,
  output logic [HIST_W-1:0] o_pre_hist,
  input  logic              i_ex_valid,
  input  logic [ADDR_W-1:0] i_ex_pc,
  input  logic              i_ex_br,
  input  logic              i_ex_uncond,
  input  logic              i_ex_taken,
  input  logic [ADDR_W-1:0] i_ex_target,
  input  logic [HIST_W-1:0] i_ex_hist,
  input  logic              i_ex_mispred
);

  localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int PHT_N = 1 << PHT_IDX_W;

  localparam logic [CTR_W-1:0] CTR_WEAK_T = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN    = {CTR_W{1'b0}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              r_btb_vld [BTB_N];
  logic              r_btb_unc [BTB_N];
  logic [TAG_W-1:0]  r_btb_tag [BTB_N];
  logic [ADDR_W-1:0] r_btb_tgt [BTB_N];
  logic [CTR_W-1:0]  r_pht     [PHT_N];
  logic [HIST_W-1:0] r_ghr;

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [BTB_IDX_W-1:0] w_bidx;
  logic [TAG_W-1:0]     w_tag;
  logic [PHT_IDX_W-1:0] w_pidx;
  logic                 w_hit;
  logic                 w_unc;
  logic                 w_ctr_t;
  logic                 w_jmp;

  assign w_bidx  = i_pc[BTB_IDX_W+1:2];
  assign w_tag   = i_pc[ADDR_W-1:BTB_IDX_W+2];
  assign w_pidx  = i_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);
  assign w_hit   = r_btb_vld[w_bidx] && (r_btb_tag[w_bidx] == w_tag);
  assign w_unc   = r_btb_unc[w_bidx];
  assign w_ctr_t = r_pht[w_pidx][CTR_W-1];
  assign w_jmp   = w_hit && (w_unc || w_ctr_t);

  // Outputs forced quiet while reset is held, regardless of array contents.
  assign o_pre_jmp    = !rst && w_jmp;
  assign o_pre_target = o_pre_jmp ? r_btb_tgt[w_bidx] : '0;
  assign o_pre_hist   = rst ? '0 : r_ghr;

  // ---------------------------------------------------------------------------
  // EX-side decode
  // ---------------------------------------------------------------------------
  logic                 w_ex_br;     // conditional, after uncond override
  logic                 w_ex_btb_we;
  logic [BTB_IDX_W-1:0] w_ex_bidx;
  logic [TAG_W-1:0]     w_ex_tag;
  logic [PHT_IDX_W-1:0] w_ex_pidx;
  logic [CTR_W-1:0]     w_ex_ctr;
  logic [CTR_W-1:0]     w_ex_ctr_nxt;

  assign w_ex_br     = i_ex_br && !i_ex_uncond;
  assign w_ex_btb_we = i_ex_taken && (i_ex_br || i_ex_uncond);
  assign w_ex_bidx   = i_ex_pc[BTB_IDX_W+1:2];
  assign w_ex_tag    = i_ex_pc[ADDR_W-1:BTB_IDX_W+2];
  assign w_ex_pidx   = i_ex_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(i_ex_hist);
  assign w_ex_ctr    = r_pht[w_ex_pidx];

  // Saturating update: hold at the rails instead of wrapping.
  always_comb begin
    w_ex_ctr_nxt = w_ex_ctr;
    if (i_ex_taken) begin
      if (w_ex_ctr != CTR_MAX) w_ex_ctr_nxt = w_ex_ctr + 1'b1;
    end else begin
      if (w_ex_ctr != CTR_MIN) w_ex_ctr_nxt = w_ex_ctr - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // History next-values. A one-bit history has no bits to keep, so the shift
  // degenerates to just the new outcome.
  // ---------------------------------------------------------------------------
  logic [HIST_W-1:0] w_ghr_shift;
  logic [HIST_W-1:0] w_ghr_rec;

  generate
    if (HIST_W == 1) begin : g_hist1
      assign w_ghr_shift = w_jmp;
      assign w_ghr_rec   = w_ex_br ? i_ex_taken : i_ex_hist;
    end else begin : g_histn
      assign w_ghr_shift = {r_ghr[HIST_W-2:0], w_jmp};
      // A mispredicted branch restarts history from its checkpoint plus its
      // real outcome; other transfers never shifted, so the checkpoint stands.
      assign w_ghr_rec   = w_ex_br ? {i_ex_hist[HIST_W-2:0], i_ex_taken}
                                   : i_ex_hist;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Resettable state: BTB valid/kind bits, PHT, GHR
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_N; i++) begin
        r_btb_vld[i] <= 1'b0;
        r_btb_unc[i] <= 1'b0;
      end
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= CTR_WEAK_T;
      r_ghr <= '0;
    end else if (i_rdy) begin
      if (i_ex_valid && w_ex_br) r_pht[w_ex_pidx] <= w_ex_ctr_nxt;
      if (i_ex_valid && w_ex_btb_we) begin
        r_btb_vld[w_ex_bidx] <= 1'b1;
        r_btb_unc[w_ex_bidx] <= i_ex_uncond;
      end
      // Recovery outranks the speculative shift from the same cycle.
      if (i_ex_valid && i_ex_mispred)
        r_ghr <= w_ghr_rec;
      else if (i_fetch_adv && w_hit && !w_unc)
        r_ghr <= w_ghr_shift;
    end
  end

  // Tag/target payload is qualified by the valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!rst && i_rdy && i_ex_valid && w_ex_btb_we) begin
      r_btb_tag[w_ex_bidx] <= w_ex_tag;
      r_btb_tgt[w_ex_bidx] <= i_ex_target;
    end
  end

  // Word-aligned PCs: the byte-offset bits never index anything.
  logic w_unused;
  assign w_unused = ^{i_pc[1:0], i_ex_pc[1:0]};

endmodule
